// File: rtl/bp_me_cce_mem_arbiter_pkg.sv
// Shared types and configuration for the CCE-to-memory arbiter.
package bp_me_cce_mem_arbiter_pkg;

    typedef enum logic [3:0] {
        e_bp_inv_cfg     = 4'd0,
        e_bp_default_cfg = 4'd1
    } bp_params_e;

    localparam int paddr_width_p      = 40;
    localparam int cce_block_width_p  = 64;
    localparam int lce_id_width_p     = 4;
    localparam int lce_assoc_p        = 8;
    localparam int lce_assoc_width_lp = $clog2(lce_assoc_p);

    typedef struct packed {
        logic [lce_assoc_width_lp-1:0] way_id;
        logic [lce_id_width_p-1:0]     lce_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [3:0]                msg_type;
        bp_cce_mem_payload_s       payload;
        logic [paddr_width_p-1:0]  addr;
        logic [2:0]                size;
    } bp_cce_mem_msg_header_s;

    typedef struct packed {
        bp_cce_mem_msg_header_s        header;
        logic [cce_block_width_p-1:0]  data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

endpackage

// File: rtl/bp_me_cce_mem_arbiter_tracker.sv
// Small 1r1w FIFO holding the requester id of every outstanding command.
// Enqueue and dequeue may happen together; a full FIFO never accepts,
// even when a dequeue happens in the same cycle.
module bp_me_cce_mem_arbiter_tracker #(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int ptr_width_lp = $clog2(els_p);

    logic [width_p-1:0]      mem_q [els_p];
    logic [width_p-1:0]      mem_d [els_p];
    logic [ptr_width_lp-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [ptr_width_lp:0]   count_q, count_d;
    logic                    enq_s, deq_s;

    assign ready_o = (count_q != (ptr_width_lp+1)'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rd_q];
    assign enq_s   = v_i & ready_o;
    assign deq_s   = yumi_i & v_o;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (enq_s) begin
            mem_d[wr_q] = data_i;
            wr_d        = wr_q + ptr_width_lp'(1);
        end else begin
            wr_d        = wr_q;
        end
        if (deq_s) begin
            rd_d = rd_q + ptr_width_lp'(1);
        end else begin
            rd_d = rd_q;
        end
        case ({enq_s, deq_s})
            2'b10:   count_d = count_q + (ptr_width_lp+1)'(1);
            2'b01:   count_d = count_q - (ptr_width_lp+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every tracked entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/bp_me_cce_mem_arbiter.sv
// Round-robin arbiter sharing one CCE-to-memory port among several
// requesters; in-order responses are steered back by a source tracker.
module bp_me_cce_mem_arbiter
    import bp_me_cce_mem_arbiter_pkg::*;
#(
    parameter bp_params_e bp_params_p       = e_bp_inv_cfg,
    parameter int         num_req_p         = 2,
    parameter int         max_outstanding_p = 4,
    localparam int        req_id_width_lp   = $clog2(num_req_p)
) (
    input  logic                                           clk_i,
    input  logic                                           reset_i,
    input  logic [num_req_p-1:0][cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic [num_req_p-1:0]                           mem_cmd_v_i,
    output logic [num_req_p-1:0]                           mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0]                mem_cmd_o,
    output logic                                           mem_cmd_v_o,
    input  logic                                           mem_cmd_ready_i,
    input  logic [cce_mem_msg_width_lp-1:0]                mem_resp_i,
    input  logic                                           mem_resp_v_i,
    output logic                                           mem_resp_yumi_o,
    output logic [num_req_p-1:0][cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic [num_req_p-1:0]                           mem_resp_v_o,
    input  logic [num_req_p-1:0]                           mem_resp_yumi_i,
    output logic                                           error_o
);

    if (num_req_p < 2 || num_req_p > 8) begin : g_bad_num_req
        $fatal(1, "num_req_p must be within 2..8");
    end
    if (max_outstanding_p < 2 || max_outstanding_p > 16
        || (max_outstanding_p & (max_outstanding_p - 1)) != 0) begin : g_bad_outstanding
        $fatal(1, "max_outstanding_p must be a power of two within 2..16");
    end
    if (bp_params_p != e_bp_inv_cfg && bp_params_p != e_bp_default_cfg) begin : g_bad_cfg
        $fatal(1, "unknown bp_params_p");
    end

    logic [req_id_width_lp-1:0] rr_q, rr_d;
    logic                       error_q, error_d;
    logic [req_id_width_lp-1:0] grant_id_s;
    logic                       any_v_s;
    logic                       accept_s;
    logic                       trk_ready_s;
    logic                       trk_v_s;
    logic [req_id_width_lp-1:0] head_s;

    // Rotating priority search starting at rr_q, wrapping at num_req_p.
    always_comb begin : arb
        logic [req_id_width_lp:0] sum_v;
        logic [req_id_width_lp:0] idx_v;
        grant_id_s = '0;
        any_v_s    = 1'b0;
        sum_v      = '0;
        idx_v      = '0;
        for (int i = 0; i < num_req_p; i++) begin
            sum_v = {1'b0, rr_q} + (req_id_width_lp+1)'(i);
            idx_v = (sum_v >= (req_id_width_lp+1)'(num_req_p))
                  ? sum_v - (req_id_width_lp+1)'(num_req_p) : sum_v;
            if (!any_v_s && mem_cmd_v_i[idx_v[req_id_width_lp-1:0]]) begin
                any_v_s    = 1'b1;
                grant_id_s = idx_v[req_id_width_lp-1:0];
            end else begin
                any_v_s    = any_v_s;
            end
        end
    end

    assign mem_cmd_o   = mem_cmd_i[grant_id_s];
    assign mem_cmd_v_o = any_v_s & trk_ready_s & ~reset_i;
    assign accept_s    = mem_cmd_v_o & mem_cmd_ready_i;

    // Only the granted requester sees ready, and only on an actual accept.
    always_comb begin
        mem_cmd_ready_o = '0;
        if (accept_s) begin
            mem_cmd_ready_o[grant_id_s] = 1'b1;
        end else begin
            mem_cmd_ready_o = '0;
        end
    end

    // Advance the round-robin pointer past the requester just served.
    always_comb begin
        rr_d = rr_q;
        if (accept_s) begin
            rr_d = (grant_id_s == req_id_width_lp'(num_req_p - 1))
                 ? '0 : grant_id_s + req_id_width_lp'(1);
        end else begin
            rr_d = rr_q;
        end
    end

    // Steer the response to the requester at the tracker head.
    always_comb begin
        mem_resp_v_o = '0;
        if (mem_resp_v_i && trk_v_s && !reset_i) begin
            mem_resp_v_o[head_s] = 1'b1;
        end else begin
            mem_resp_v_o = '0;
        end
    end

    assign mem_resp_yumi_o = mem_resp_yumi_i[head_s] & mem_resp_v_o[head_s];

    // Response payload is broadcast unchanged to every requester.
    always_comb begin
        for (int i = 0; i < num_req_p; i++) begin
            mem_resp_o[i] = mem_resp_i;
        end
    end

    // A response arriving with nothing outstanding is a protocol error.
    always_comb begin
        error_d = error_q | (mem_resp_v_i & ~trk_v_s);
    end

    // Pointer and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q    <= '0;
            error_q <= 1'b0;
        end else begin
            rr_q    <= rr_d;
            error_q <= error_d;
        end
    end

    assign error_o = error_q;

    bp_me_cce_mem_arbiter_tracker #(
        .width_p (req_id_width_lp),
        .els_p   (max_outstanding_p)
    ) tracker (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  (grant_id_s),
        .v_i     (accept_s),
        .ready_o (trk_ready_s),
        .data_o  (head_s),
        .v_o     (trk_v_s),
        .yumi_i  (mem_resp_yumi_o)
    );

endmodule
